// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole CYC, plus a bus watchdog.
// Latency: the grant is registered, so s_cyc_o rises one cycle after a request; the data path is combinational.
// Backpressure: the loser waits with no ack/err until the owner drops CYC; one idle bubble separates grants.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Count value seen on the TIMEOUT-th consecutive unanswered strobe cycle.
  localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic        last_grant;
  logic [15:0] wd_cnt;
  logic        wd_stall;
  logic        wd_fire;

  // Slave-side mux of the granted master; everything idles at zero when nobody owns the bus.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_cyc_i & m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_cyc_i & m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // A slave ack in the would-be firing cycle suppresses the watchdog because the stall term needs no ack/err.
  assign wd_stall  = s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_fire   = (TIMEOUT != 0) && wd_stall && (wd_cnt == WD_LAST);
  assign timeout_o = wd_fire;

  // Terminations reach only the granted master; read data is broadcast but held at zero during reset.
  assign m0_ack_o = (state == GNT0) & s_ack_i;
  assign m1_ack_o = (state == GNT1) & s_ack_i;
  assign m0_err_o = (state == GNT0) & (s_err_i | wd_fire);
  assign m1_err_o = (state == GNT1) & (s_err_i | wd_fire);
  assign m0_dat_o = rst_i ? '0 : s_dat_i;
  assign m1_dat_o = rst_i ? '0 : s_dat_i;

  // Grant FSM: round-robin on ties, grant locked while the owner keeps CYC, release via IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= last_grant ? GNT0 : GNT1;
          else if (m0_cyc_i)        state <= GNT0;
          else if (m1_cyc_i)        state <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            last_grant <= 1'b0;
            state      <= IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            last_grant <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog counts consecutive unanswered strobe cycles and restarts on any answer, idle strobe or firing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= 16'd0;
    end else if ((TIMEOUT == 0) || !wd_stall || wd_fire) begin
      wd_cnt <= 16'd0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

endmodule
